// File: rtl/serial_console_port.sv
// Serial console port: byte-wide device endpoint for the processor's serial IO.
// Holds two independent first-word-fall-through byte FIFOs: TX carries bytes
// from the CPU to the host stream, RX carries bytes from the host to the CPU.
// All outputs are decoded from registered state only.
module serial_console_port #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [7:0]        cpu_wdata,
  input  logic              cpu_wren,
  input  logic              cpu_rden,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_rvalid,
  output logic              cpu_wready,
  output logic [7:0]        host_tx_data,
  output logic              host_tx_valid,
  input  logic              host_tx_ready,
  input  logic [7:0]        host_rx_data,
  input  logic              host_rx_valid,
  output logic              host_rx_ready,
  input  logic              flag_clear,
  output logic [ADDR_W:0]   tx_count,
  output logic [ADDR_W:0]   rx_count,
  output logic              tx_overflow,
  output logic              rx_underflow
);

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] COUNT_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  // Byte storage; deliberately not reset, only the pointers/counts are.
  logic [7:0] tx_mem_q [DEPTH];
  logic [7:0] rx_mem_q [DEPTH];

  logic [ADDR_W-1:0] tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
  logic [ADDR_W-1:0] rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
  logic [ADDR_W:0]   tx_count_q, tx_count_d;
  logic [ADDR_W:0]   rx_count_q, rx_count_d;
  logic              tx_overflow_q, tx_overflow_d;
  logic              rx_underflow_q, rx_underflow_d;

  logic tx_push, tx_pop, rx_push, rx_pop;

  // Handshake decode from registered occupancy, so no input reaches an output.
  always_comb begin
    cpu_wready    = (tx_count_q != FULL_COUNT);
    host_tx_valid = (tx_count_q != '0);
    host_rx_ready = (rx_count_q != FULL_COUNT);
    cpu_rvalid    = (rx_count_q != '0);
    host_tx_data  = host_tx_valid ? tx_mem_q[tx_rd_ptr_q] : 8'h00;
    cpu_rdata     = cpu_rvalid ? rx_mem_q[rx_rd_ptr_q] : 8'h00;
    tx_count      = tx_count_q;
    rx_count      = rx_count_q;
    tx_overflow   = tx_overflow_q;
    rx_underflow  = rx_underflow_q;
    tx_push       = cpu_wren && cpu_wready;
    tx_pop        = host_tx_valid && host_tx_ready;
    rx_push       = host_rx_valid && host_rx_ready;
    rx_pop        = cpu_rden && cpu_rvalid;
  end

  // Next-state: pointer advance (wraps naturally), occupancy and sticky flags.
  always_comb begin
    tx_wr_ptr_d = tx_push ? tx_wr_ptr_q + PTR_ONE : tx_wr_ptr_q;
    tx_rd_ptr_d = tx_pop  ? tx_rd_ptr_q + PTR_ONE : tx_rd_ptr_q;
    rx_wr_ptr_d = rx_push ? rx_wr_ptr_q + PTR_ONE : rx_wr_ptr_q;
    rx_rd_ptr_d = rx_pop  ? rx_rd_ptr_q + PTR_ONE : rx_rd_ptr_q;

    tx_count_d = tx_count_q;
    case ({tx_push, tx_pop})
      2'b10:   tx_count_d = tx_count_q + COUNT_ONE;
      2'b01:   tx_count_d = tx_count_q - COUNT_ONE;
      default: tx_count_d = tx_count_q;
    endcase

    rx_count_d = rx_count_q;
    case ({rx_push, rx_pop})
      2'b10:   rx_count_d = rx_count_q + COUNT_ONE;
      2'b01:   rx_count_d = rx_count_q - COUNT_ONE;
      default: rx_count_d = rx_count_q;
    endcase

    // A new error event beats a clear arriving in the same cycle.
    tx_overflow_d = tx_overflow_q;
    if (cpu_wren && !cpu_wready) tx_overflow_d = 1'b1;
    else if (flag_clear)         tx_overflow_d = 1'b0;

    rx_underflow_d = rx_underflow_q;
    if (cpu_rden && !cpu_rvalid) rx_underflow_d = 1'b1;
    else if (flag_clear)         rx_underflow_d = 1'b0;
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      tx_wr_ptr_q    <= '0;
      tx_rd_ptr_q    <= '0;
      rx_wr_ptr_q    <= '0;
      rx_rd_ptr_q    <= '0;
      tx_count_q     <= '0;
      rx_count_q     <= '0;
      tx_overflow_q  <= 1'b0;
      rx_underflow_q <= 1'b0;
    end else begin
      tx_wr_ptr_q    <= tx_wr_ptr_d;
      tx_rd_ptr_q    <= tx_rd_ptr_d;
      rx_wr_ptr_q    <= rx_wr_ptr_d;
      rx_rd_ptr_q    <= rx_rd_ptr_d;
      tx_count_q     <= tx_count_d;
      rx_count_q     <= rx_count_d;
      tx_overflow_q  <= tx_overflow_d;
      rx_underflow_q <= rx_underflow_d;
    end
  end

  // Storage writes; suppressed during reset so strobes there have no effect.
  always_ff @(posedge clock) begin
    if (!reset && tx_push) tx_mem_q[tx_wr_ptr_q] <= cpu_wdata;
    if (!reset && rx_push) rx_mem_q[rx_wr_ptr_q] <= host_rx_data;
  end

endmodule

// File: tb/tb_serial_console_port.sv
// Self-checking bench for serial_console_port: directed scenarios plus a
// randomized run, all checked against a queue-based behavioural model.
module tb_serial_console_port;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [7:0]        cpu_wdata = '0;
  logic              cpu_wren = 1'b0;
  logic              cpu_rden = 1'b0;
  logic [7:0]        cpu_rdata;
  logic              cpu_rvalid;
  logic              cpu_wready;
  logic [7:0]        host_tx_data;
  logic              host_tx_valid;
  logic              host_tx_ready = 1'b0;
  logic [7:0]        host_rx_data = '0;
  logic              host_rx_valid = 1'b0;
  logic              host_rx_ready;
  logic              flag_clear = 1'b0;
  logic [ADDR_W:0]   tx_count;
  logic [ADDR_W:0]   rx_count;
  logic              tx_overflow;
  logic              rx_underflow;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model: two byte queues and two sticky bits.
  logic [7:0] m_tx[$];
  logic [7:0] m_rx[$];
  logic       m_ovf = 1'b0;
  logic       m_unf = 1'b0;

  serial_console_port #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset(reset),
    .cpu_wdata(cpu_wdata), .cpu_wren(cpu_wren), .cpu_rden(cpu_rden),
    .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid), .cpu_wready(cpu_wready),
    .host_tx_data(host_tx_data), .host_tx_valid(host_tx_valid),
    .host_tx_ready(host_tx_ready), .host_rx_data(host_rx_data),
    .host_rx_valid(host_rx_valid), .host_rx_ready(host_rx_ready),
    .flag_clear(flag_clear), .tx_count(tx_count), .rx_count(rx_count),
    .tx_overflow(tx_overflow), .rx_underflow(rx_underflow)
  );

  always #5 clock = ~clock;

  function automatic logic [29:0] model_vec();
    logic [7:0] rd, td;
    rd = (m_rx.size() != 0) ? m_rx[0] : 8'h00;
    td = (m_tx.size() != 0) ? m_tx[0] : 8'h00;
    return {rd, m_rx.size() != 0, m_tx.size() < DEPTH, td, m_tx.size() != 0,
            m_rx.size() < DEPTH, 4'(m_tx.size()), 4'(m_rx.size()), m_ovf, m_unf};
  endfunction

  // Advance the model by one clock using the currently driven inputs, then clock the DUT.
  task automatic step();
    bit tx_rdy, tx_vld, rx_rdy, rx_vld;
    if (reset) begin
      m_tx.delete();
      m_rx.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      tx_rdy = m_tx.size() < DEPTH;
      tx_vld = m_tx.size() != 0;
      rx_rdy = m_rx.size() < DEPTH;
      rx_vld = m_rx.size() != 0;
      if (tx_vld && host_tx_ready) void'(m_tx.pop_front());
      if (cpu_wren && tx_rdy) m_tx.push_back(cpu_wdata);
      if (rx_vld && cpu_rden) void'(m_rx.pop_front());
      if (host_rx_valid && rx_rdy) m_rx.push_back(host_rx_data);
      if (cpu_wren && !tx_rdy) m_ovf = 1'b1;
      else if (flag_clear) m_ovf = 1'b0;
      if (cpu_rden && !rx_vld) m_unf = 1'b1;
      else if (flag_clear) m_unf = 1'b0;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    host_tx_ready = 1'b0;
    cpu_wren = 1'b1; cpu_wdata = 8'hAA;
    host_rx_valid = 1'b1; host_rx_data = 8'h55;
    cpu_rden = 1'b1;
    step();
    step();
    reset = 1'b0; cpu_wren = 1'b0; host_rx_valid = 1'b0; cpu_rden = 1'b0;
    vectors++;
    if ({cpu_wready, host_rx_ready, cpu_rvalid, host_tx_valid} !== 4'b1100) begin
      miscompares++;
      $display("[TB] FAIL reset_handshake got %b exp 1100",
               {cpu_wready, host_rx_ready, cpu_rvalid, host_tx_valid});
    end
    vectors++;
    if ({tx_count, rx_count, tx_overflow, rx_underflow, cpu_rdata, host_tx_data} !== 26'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_state got %h exp 0",
               {tx_count, rx_count, tx_overflow, rx_underflow, cpu_rdata, host_tx_data});
    end
  endtask

  task automatic test_tx_order();
    logic [7:0] e;
    host_tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cpu_wren = 1'b1;
      cpu_wdata = 8'h41 + 8'(i);
      step();
    end
    cpu_wren = 1'b0;
    host_tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      e = 8'h41 + 8'(i);
      vectors++;
      if (host_tx_data !== e || host_tx_valid !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL tx_order_data[%0d] got %h/%b exp %h/1", i, host_tx_data, host_tx_valid, e);
      end
      vectors++;
      if (tx_count !== 4'(3 - i)) begin
        miscompares++;
        $display("[TB] FAIL tx_order_count[%0d] got %0d exp %0d", i, tx_count, 3 - i);
      end
      step();
    end
    host_tx_ready = 1'b0;
    vectors++;
    if (host_tx_valid !== 1'b0 || tx_count !== 4'd0) begin
      miscompares++;
      $display("[TB] FAIL tx_order_drained got valid %b count %0d exp 0 0", host_tx_valid, tx_count);
    end
  endtask

  task automatic test_rx_fill();
    logic [7:0] e;
    for (int i = 0; i < 9; i++) begin
      vectors++;
      if (host_rx_ready !== (i < 8)) begin
        miscompares++;
        $display("[TB] FAIL rx_fill_ready[%0d] got %b exp %b", i, host_rx_ready, i < 8);
      end
      host_rx_valid = 1'b1;
      host_rx_data = 8'h10 + 8'(i);
      step();
    end
    host_rx_valid = 1'b0;
    vectors++;
    if (rx_count !== 4'd8 || host_rx_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL rx_fill_full got count %0d ready %b exp 8 0", rx_count, host_rx_ready);
    end
    cpu_rden = 1'b1;
    for (int i = 0; i < 8; i++) begin
      e = 8'h10 + 8'(i);
      vectors++;
      if (cpu_rdata !== e || cpu_rvalid !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL rx_fill_read[%0d] got %h/%b exp %h/1", i, cpu_rdata, cpu_rvalid, e);
      end
      step();
    end
    cpu_rden = 1'b0;
    vectors++;
    if (cpu_rvalid !== 1'b0 || rx_underflow !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL rx_fill_empty got valid %b unf %b exp 0 0", cpu_rvalid, rx_underflow);
    end
  endtask

  task automatic test_tx_overflow();
    host_tx_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      cpu_wren = 1'b1;
      cpu_wdata = 8'($urandom);
      step();
    end
    cpu_wren = 1'b0;
    vectors++;
    if (tx_count !== 4'd8 || cpu_wready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL tx_ovf_full got count %0d wready %b exp 8 0", tx_count, cpu_wready);
    end
    cpu_wren = 1'b1; cpu_wdata = 8'hFF; host_tx_ready = 1'b1;
    step();
    cpu_wren = 1'b0;
    vectors++;
    if (tx_overflow !== 1'b1 || tx_count !== 4'd7 || cpu_wready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL tx_ovf_reject got ovf %b count %0d wready %b exp 1 7 1",
               tx_overflow, tx_count, cpu_wready);
    end
    for (int i = 0; i < 7; i++) begin
      vectors++;
      if (host_tx_data !== m_tx[0]) begin
        miscompares++;
        $display("[TB] FAIL tx_ovf_drain[%0d] got %h exp %h", i, host_tx_data, m_tx[0]);
      end
      step();
    end
    host_tx_ready = 1'b0;
    vectors++;
    if (host_tx_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL tx_ovf_no_extra got valid %b exp 0", host_tx_valid);
    end
    flag_clear = 1'b1;
    step();
    flag_clear = 1'b0;
    vectors++;
    if (tx_overflow !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL tx_ovf_clear got %b exp 0", tx_overflow);
    end
  endtask

  task automatic test_rx_stream();
    host_rx_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      host_rx_data = 8'($urandom);
      step();
    end
    cpu_rden = 1'b1;
    for (int i = 0; i < 20; i++) begin
      vectors++;
      if (rx_count !== 4'd4 || cpu_rdata !== m_rx[0]) begin
        miscompares++;
        $display("[TB] FAIL rx_stream[%0d] got count %0d data %h exp 4 %h", i, rx_count, cpu_rdata, m_rx[0]);
      end
      host_rx_data = 8'($urandom);
      step();
    end
    host_rx_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (cpu_rdata !== m_rx[0]) begin
        miscompares++;
        $display("[TB] FAIL rx_stream_drain[%0d] got %h exp %h", i, cpu_rdata, m_rx[0]);
      end
      step();
    end
    cpu_rden = 1'b0;
  endtask

  task automatic test_underflow();
    cpu_rden = 1'b1;
    step();
    cpu_rden = 1'b0;
    vectors++;
    if (rx_underflow !== 1'b1 || rx_count !== 4'd0) begin
      miscompares++;
      $display("[TB] FAIL unf_set got %b count %0d exp 1 0", rx_underflow, rx_count);
    end
    cpu_rden = 1'b1; flag_clear = 1'b1;
    step();
    cpu_rden = 1'b0; flag_clear = 1'b0;
    vectors++;
    if (rx_underflow !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL unf_set_wins got %b exp 1", rx_underflow);
    end
    flag_clear = 1'b1;
    step();
    flag_clear = 1'b0;
    vectors++;
    if (rx_underflow !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL unf_clear got %b exp 0", rx_underflow);
    end
  endtask

  task automatic test_random();
    logic [29:0] exp_v, got_v;
    for (int i = 0; i < 600; i++) begin
      reset         = ($urandom_range(0, 99) == 0);
      cpu_wren      = ($urandom_range(0, 99) < 55);
      cpu_wdata     = 8'($urandom);
      cpu_rden      = ($urandom_range(0, 99) < 45);
      host_tx_ready = ($urandom_range(0, 99) < 45);
      host_rx_valid = ($urandom_range(0, 99) < 55);
      host_rx_data  = 8'($urandom);
      flag_clear    = ($urandom_range(0, 99) < 10);
      step();
      exp_v = model_vec();
      got_v = {cpu_rdata, cpu_rvalid, cpu_wready, host_tx_data, host_tx_valid,
               host_rx_ready, tx_count, rx_count, tx_overflow, rx_underflow};
      vectors++;
      if (got_v !== exp_v) begin
        miscompares++;
        $display("[TB] FAIL random[%0d] got %h exp %h", i, got_v, exp_v);
      end
    end
    reset = 1'b0; cpu_wren = 1'b0; cpu_rden = 1'b0;
    host_tx_ready = 1'b0; host_rx_valid = 1'b0; flag_clear = 1'b0;
  endtask

  initial begin
    @(posedge clock);
    #1;
    test_reset();
    test_tx_order();
    test_rx_fill();
    test_tx_overflow();
    test_rx_stream();
    test_underflow();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serial_console_port.md
Name: serial_console_port

Overview:
Device-side endpoint of the processor's byte-wide serial IO interface. It consumes the bytes that data_memory emits on the write strobe and supplies the bytes that data_memory fetches on the read strobe. Two independent byte FIFOs (CPU->host TX, host->CPU RX) decouple the processor from an external valid/ready host stream used by the bench or a UART wrapper. It sits in the top level beside processor and connects to its serial_* ports.

Parameters:
DEPTH, 8, entries per FIFO; power of two, minimum 2
ADDR_W, 3, log2(DEPTH); pointer width; count width is ADDR_W+1

Ports:
clock  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
cpu_wdata  input  8  byte from processor (processor's serial_out)
cpu_wren  input  1  processor write strobe (serial_wren_out)
cpu_rden  input  1  processor read/consume strobe (serial_rden_out)
cpu_rdata  output  8  RX FIFO head byte (to processor serial_in)
cpu_rvalid  output  1  RX FIFO non-empty (to serial_valid_in)
cpu_wready  output  1  TX FIFO not full (to serial_ready_in)
host_tx_data  output  8  TX FIFO head byte toward host
host_tx_valid  output  1  TX FIFO non-empty
host_tx_ready  input  1  host accepts host_tx_data
host_rx_data  input  8  byte from host
host_rx_valid  input  1  host_rx_data valid
host_rx_ready  output  1  RX FIFO not full
flag_clear  input  1  clears sticky error flags
tx_count  output  ADDR_W+1  TX FIFO occupancy
rx_count  output  ADDR_W+1  RX FIFO occupancy
tx_overflow  output  1  sticky: cpu_wren while cpu_wready low
rx_underflow  output  1  sticky: cpu_rden while cpu_rvalid low

Behaviour:
- Reset (clock edge with reset=1): pointers, counts, flags cleared. Outputs after reset: cpu_rvalid=0, cpu_wready=1, host_tx_valid=0, host_rx_ready=1, cpu_rdata=8'h00, host_tx_data=8'h00, counts=0, flags=0. Reset overrides all simultaneous strobes. Mid-operation reset discards FIFO contents. Storage arrays are not reset.
- Each FIFO is first-word-fall-through. Head data is valid whenever valid is high. Data outputs are forced to 8'h00 while their valid is low.
- Ready and valid outputs are decoded from the registered count only. There is no combinational path from any input to any output.
- TX push: cpu_wren && cpu_wready writes cpu_wdata at the write pointer.
- TX pop: host_tx_valid && host_tx_ready advances the read pointer.
- RX push: host_rx_valid && host_rx_ready.
- RX pop: cpu_rden && cpu_rvalid.
- Latency: a byte pushed at edge N is visible on the far side's valid/data from edge N (next cycle), i.e. one cycle of minimum transit.
- Count update per FIFO:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged, both pointers advance.
- Full with pop in the same cycle: ready is low, so no push occurs. Empty: no pop occurs (valid low).
- Pointers wrap modulo DEPTH. Full is count==DEPTH; empty is count==0.
- cpu_wren while full: byte dropped, FIFO unchanged, tx_overflow<=1.
- cpu_rden while empty: ignored, rx_underflow<=1.
- Flags are sticky until flag_clear. If a set and a clear occur in the same cycle, set wins.
- Order is strict FIFO; no reordering and no duplication.

Test Plan:
- Reset with host_tx_ready=0: cpu_wready=1, host_rx_ready=1, valids=0, counts=0, flags=0.
- Write 8'h41, 8'h42, 8'h43 on consecutive cycles with host_tx_ready=0, then raise host_tx_ready: host_tx_data sequence 41,42,43 on consecutive cycles; host_tx_valid falls after 43; tx_count goes 3,2,1,0.
- Push 9 bytes 8'h10..8'h18 via host_rx with cpu_rden=0 (DEPTH=8): host_rx_ready drops after the 8th; rx_count=8; byte 18 is not accepted. Then read 8 times: cpu_rdata 10..17 in order.
- Fill TX to 8, then assert cpu_wren=1 (8'hFF) and host_tx_ready=1 in the same cycle: write rejected, tx_overflow=1, tx_count=7. Next cycle cpu_wready=1.
- Steady stream at count=4 with simultaneous RX push and pop for 20 cycles: rx_count stays 4; pointers wrap past DEPTH; data order is preserved.
- cpu_rden with RX empty: rx_underflow=1, rx_count=0. Then flag_clear together with another empty cpu_rden: flag stays 1. flag_clear alone: flag=0.
